anemo_ram_logger: RTL and testbench
===================================

Name: anemo_ram_logger

Overview:
- Avalon-MM write master directly upstream of the anemometer system's 32-bit on-chip sample RAM (5000 words).
- Takes wind-speed samples from the anemometer measurement block and timestamps them with an internal tick counter.
- Buffers records in a small FIFO and writes them into the RAM as a circular log, so the Nios software reads history instead of polling live values.

Parameters:
- NUM_WORDS, 5000, log length in 32-bit words; the pointer wraps at NUM_WORDS-1.
- BASE_ADDR, 0, byte base address of the RAM in the master's address space; must be 4-aligned.
- ADDR_W, 15, master byte-address width (covers 5000*4 bytes).
- FIFO_DEPTH, 4, record FIFO entries; power of two.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  1 = accept samples; 0 = ignore new samples but keep draining the FIFO.
- clear  in  1  single-cycle request to restart the log.
- tick  in  1  single-cycle timebase pulse (1 Hz in the system).
- sample_valid  in  1  single-cycle strobe; sample_data is valid this cycle.
- sample_data  in  8  wind speed code.
- avm_address  out  ADDR_W  byte address = BASE_ADDR + 4*wr_ptr.
- avm_write  out  1  write request.
- avm_writedata  out  32  record.
- avm_byteenable  out  4  constant 4'hF.
- avm_waitrequest  in  1  Avalon stall.
- wr_ptr  out  13  index of the next word to write.
- wrap_count  out  8  completed log wraps, saturating at 255.
- overflow  out  1  sticky: at least one sample was dropped.
- busy  out  1  FIFO non-empty or write in flight.

Behaviour:
- Reset values: avm_write=0; avm_address=BASE_ADDR; avm_writedata=0; wr_ptr=0; wrap_count=0; overflow=0; busy=0; timestamp=0; FIFO empty; pending clear flag=0.
- Timestamp: 16-bit counter, +1 on each tick, wraps 0xFFFF->0.
- Record format: [31:16] timestamp, [15:8] 8'h00, [7:0] sample_data.
  - If tick and sample_valid occur in the same cycle, the record uses the pre-increment timestamp.
- Push: on sample_valid & enable.
  - If the FIFO is full and no pop occurs this cycle: the sample is dropped and overflow is set.
  - If the FIFO is full but a pop occurs this cycle: the push succeeds.
- FSM IDLE:
  - Stays in IDLE while the FIFO is empty or a clear is pending.
  - Otherwise, next cycle: avm_write=1, address/data from the FIFO head; go to WRITE.
- FSM WRITE:
  - avm_address, avm_writedata and avm_write held stable while avm_waitrequest=1.
  - When avm_waitrequest=0: pop the FIFO; wr_ptr advances (NUM_WORDS-1 -> 0, wrap_count +1 saturating); avm_write=0; return to IDLE.
  - Sustained rate is one word per 2 cycles; latency from sample push to avm_write is 2 cycles with no stall.
- Clear:
  - clear sets the pending flag.
  - The clear is applied only in IDLE: flush FIFO, wr_ptr=0, wrap_count=0, overflow=0, timestamp=0.
  - A clear arriving during WRITE never aborts the transfer; the accepted word completes first, then the clear is applied.
  - A sample arriving in the same cycle the clear is applied is discarded.
- enable=0 mid-stream: FIFO contents still written.
- busy = FIFO non-empty | avm_write.
- reset mid-WRITE drops avm_write in the next cycle; the interconnect is reset together with this block.

Decomposition:
- Shared package anemo_logger_pkg holds:
  - record field positions (TS_MSB=31, TS_LSB=16, SPD_MSB=7, SPD_LSB=0);
  - RECORD_W=32;
  - FSM state enum {IDLE, WRITE}.
- One sub-module: anemo_sync_fifo, a generic synchronous FIFO.
  - Ports: push, pop, din, dout, full, empty.
  - Simultaneous push and pop are allowed when full.
  - Same synchronous active-high reset.

Test Plan:
- Sample 0x2A with timestamp 3, no waitrequest -> avm_write pulses 2 cycles after sample_valid; avm_address=BASE_ADDR; writedata=0x0003002A; wr_ptr 0->1.
- waitrequest held high 5 cycles -> address and data stable all 5 cycles; a single pop; wr_ptr advances exactly once.
- 6 back-to-back samples with waitrequest high for 20 cycles (FIFO_DEPTH=4) -> overflow=1; exactly 4 records reach RAM in order; overflow stays set until clear.
- wr_ptr preloaded to 4999 and one sample written -> write goes to BASE_ADDR+19996; wr_ptr=0; wrap_count=1.
- clear asserted during a stalled write -> write completes, then wr_ptr=0, FIFO empty, wrap_count=0, timestamp=0.
- tick and sample_valid in the same cycle with timestamp 7 -> record timestamp field=7; next record timestamp=8.

Source files
------------

// File: rtl/anemo_logger_pkg.sv
// Shared definitions for the anemometer RAM logger: record layout and write-master states.
package anemo_logger_pkg;

  localparam int RECORD_W = 32;
  localparam int TS_MSB   = 31;
  localparam int TS_LSB   = 16;
  localparam int SPD_MSB  = 7;
  localparam int SPD_LSB  = 0;

  typedef enum logic {IDLE, WRITE} state_t;

  // Packs a timestamp and speed code into one log word; unused middle byte stays zero.
  function automatic logic [RECORD_W-1:0] make_record(input logic [15:0] ts,
                                                      input logic [7:0]  spd);
    logic [RECORD_W-1:0] rec;
    rec                  = '0;
    rec[TS_MSB:TS_LSB]   = ts;
    rec[SPD_MSB:SPD_LSB] = spd;
    return rec;
  endfunction

endpackage

// File: rtl/anemo_sync_fifo.sv
// Generic synchronous FIFO; a push into a full FIFO is accepted only when a pop happens in the same cycle.
module anemo_sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      rd_ptr;
  logic [AW:0]      wr_ptr;
  logic             do_push;
  logic             do_pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty   = (rd_ptr == wr_ptr);
  assign full    = (rd_ptr[AW] != wr_ptr[AW]) && (rd_ptr[AW-1:0] == wr_ptr[AW-1:0]);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/anemo_ram_logger.sv
// Timestamps wind-speed samples and writes them as a circular log into the sample RAM over Avalon-MM.
module anemo_ram_logger
  import anemo_logger_pkg::*;
#(
  parameter int NUM_WORDS  = 5000,
  parameter int BASE_ADDR  = 0,
  parameter int ADDR_W     = 15,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              clear,
  input  logic              tick,
  input  logic              sample_valid,
  input  logic [7:0]        sample_data,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_write,
  output logic [31:0]       avm_writedata,
  output logic [3:0]        avm_byteenable,
  input  logic              avm_waitrequest,
  output logic [12:0]       wr_ptr,
  output logic [7:0]        wrap_count,
  output logic              overflow,
  output logic              busy
);

  localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);
  localparam logic [12:0]       LAST_PTR = 13'(NUM_WORDS - 1);

  state_t              state;
  logic                clear_pending;
  logic [15:0]         timestamp;
  logic                clear_now;
  logic                sample_in;
  logic                fifo_push;
  logic                fifo_pop;
  logic                fifo_reset;
  logic                fifo_full;
  logic                fifo_empty;
  logic [RECORD_W-1:0] fifo_dout;

  // A clear only takes effect between transfers; it also flushes the FIFO through its reset.
  assign clear_now      = (state == IDLE) & (clear | clear_pending);
  assign fifo_pop       = (state == WRITE) & ~avm_waitrequest;
  assign sample_in      = sample_valid & enable & ~clear_now;
  assign fifo_push      = sample_in & (~fifo_full | fifo_pop);
  assign fifo_reset     = reset | clear_now;
  assign busy           = ~fifo_empty | avm_write;
  assign avm_byteenable = 4'hF;

  anemo_sync_fifo #(
    .WIDTH (RECORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (fifo_reset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (make_record(timestamp, sample_data)),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      avm_write     <= 1'b0;
      avm_address   <= BASE;
      avm_writedata <= '0;
      wr_ptr        <= '0;
      wrap_count    <= '0;
      overflow      <= 1'b0;
      timestamp     <= '0;
      clear_pending <= 1'b0;
    end else begin
      timestamp <= timestamp + 16'(tick);
      if (sample_in & fifo_full & ~fifo_pop) overflow <= 1'b1;

      case (state)
        IDLE: begin
          if (clear_now) begin
            wr_ptr        <= '0;
            wrap_count    <= '0;
            overflow      <= 1'b0;
            timestamp     <= '0;
            clear_pending <= 1'b0;
          end else if (!fifo_empty) begin
            avm_write     <= 1'b1;
            avm_address   <= BASE + ADDR_W'({wr_ptr, 2'b00});
            avm_writedata <= fifo_dout;
            state         <= WRITE;
          end
        end
        WRITE: begin
          if (clear) clear_pending <= 1'b1;
          // Address and data stay frozen until the slave drops waitrequest.
          if (!avm_waitrequest) begin
            avm_write <= 1'b0;
            state     <= IDLE;
            if (wr_ptr == LAST_PTR) begin
              wr_ptr <= '0;
              if (wrap_count != 8'hFF) wrap_count <= wrap_count + 8'd1;
            end else begin
              wr_ptr <= wr_ptr + 13'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_anemo_ram_logger.sv
// Self-checking bench for anemo_ram_logger: vector table, directed corner cases and a random run against a queue model.
module tb_anemo_ram_logger;

  localparam int NUM_WORDS  = 5000;
  localparam int BASE_ADDR  = 0;
  localparam int ADDR_W     = 15;
  localparam int FIFO_DEPTH = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              enable;
  logic              clear;
  logic              tick;
  logic              sample_valid;
  logic [7:0]        sample_data;
  logic [ADDR_W-1:0] avm_address;
  logic              avm_write;
  logic [31:0]       avm_writedata;
  logic [3:0]        avm_byteenable;
  logic              avm_waitrequest;
  logic [12:0]       wr_ptr;
  logic [7:0]        wrap_count;
  logic              overflow;
  logic              busy;

  always #5 clk = ~clk;

  anemo_ram_logger #(
    .NUM_WORDS  (NUM_WORDS),
    .BASE_ADDR  (BASE_ADDR),
    .ADDR_W     (ADDR_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .enable          (enable),
    .clear           (clear),
    .tick            (tick),
    .sample_valid    (sample_valid),
    .sample_data     (sample_data),
    .avm_address     (avm_address),
    .avm_write       (avm_write),
    .avm_writedata   (avm_writedata),
    .avm_byteenable  (avm_byteenable),
    .avm_waitrequest (avm_waitrequest),
    .wr_ptr          (wr_ptr),
    .wrap_count      (wrap_count),
    .overflow        (overflow),
    .busy            (busy)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Transaction-level model: a queue of pending records plus the logger's visible bookkeeping.
  logic [31:0] m_q[$];
  bit          m_write;
  int          m_addr;
  logic [31:0] m_data;
  int          m_ptr;
  int          m_wraps;
  bit          m_ovf;
  bit          m_pend;
  int          m_ts;
  logic [31:0] dut_log[$];

  typedef struct {
    bit          sv;
    logic [7:0]  sd;
    bit          tk;
    bit          wr;
    bit          exp_write;
    logic [31:0] exp_data;
    logic [14:0] exp_addr;
    logic [12:0] exp_ptr;
  } vec_t;

  vec_t vecs[7];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic modelEdge();
    bit          apply;
    bit          pop;
    int          size0;
    logic [31:0] rec;
    logic [15:0] ts16;
    if (reset) begin
      m_q.delete();
      m_write = 0; m_addr = BASE_ADDR; m_data = '0; m_ptr = 0;
      m_wraps = 0; m_ovf = 0; m_pend = 0; m_ts = 0;
      return;
    end
    apply = !m_write && (m_pend || clear);
    if (apply) begin
      m_q.delete();
      m_ptr = 0; m_wraps = 0; m_ovf = 0; m_ts = 0; m_pend = 0;
      return;
    end
    if (clear) m_pend = 1;
    ts16  = m_ts[15:0];
    rec   = {ts16, 8'h00, sample_data};
    m_ts  = (m_ts + int'(tick)) % 65536;
    pop   = m_write && !avm_waitrequest;
    size0 = m_q.size();
    if (pop) begin
      void'(m_q.pop_front());
      m_write = 0;
      if (m_ptr == NUM_WORDS - 1) begin
        m_ptr = 0;
        if (m_wraps < 255) m_wraps++;
      end else begin
        m_ptr++;
      end
    end else if (!m_write && size0 > 0) begin
      m_write = 1;
      m_addr  = (BASE_ADDR + 4 * m_ptr) % (1 << ADDR_W);
      m_data  = m_q[0];
    end
    if (sample_valid && enable) begin
      if (size0 < FIFO_DEPTH || pop) m_q.push_back(rec);
      else m_ovf = 1;
    end
  endtask

  task automatic checkModel();
    checkOutput("avm_write", avm_write, m_write);
    checkOutput("avm_address", avm_address, 32'(m_addr));
    checkOutput("avm_writedata", avm_writedata, m_data);
    checkOutput("avm_byteenable", avm_byteenable, 4'hF);
    checkOutput("wr_ptr", wr_ptr, 32'(m_ptr));
    checkOutput("wrap_count", wrap_count, 32'(m_wraps));
    checkOutput("overflow", overflow, m_ovf);
    checkOutput("busy", busy, (m_q.size() > 0) || m_write);
  endtask

  // One clock: drive inputs, log any accepted RAM write, advance the model, then compare after the edge.
  task automatic applyStimulus(input bit sv, input logic [7:0] sd, input bit tk, input bit wr,
                               input bit en = 1'b1, input bit clr = 1'b0, input bit rst = 1'b0);
    sample_valid    = sv;
    sample_data     = sd;
    tick            = tk;
    avm_waitrequest = wr;
    enable          = en;
    clear           = clr;
    reset           = rst;
    if (avm_write === 1'b1 && !wr) dut_log.push_back(avm_writedata);
    @(posedge clk);
    modelEdge();
    #1;
    checkModel();
  endtask

  initial begin
    reset = 1'b1; enable = 1'b1; clear = 1'b0; tick = 1'b0;
    sample_valid = 1'b0; sample_data = '0; avm_waitrequest = 1'b0;

    // Reset state
    applyStimulus(0, 8'h00, 0, 0, 1, 0, 1);
    applyStimulus(0, 8'h00, 0, 0, 1, 0, 1);
    checkOutput("reset_write", avm_write, 0);
    checkOutput("reset_addr", avm_address, BASE_ADDR);
    checkOutput("reset_ptr", wr_ptr, 0);
    checkOutput("reset_busy", busy, 0);

    // Three ticks, then sample 0x2A written at BASE_ADDR two cycles later
    vecs[0] = '{0, 8'h00, 1, 0, 0, 32'h0000_0000, 15'h0, 13'd0};
    vecs[1] = '{0, 8'h00, 1, 0, 0, 32'h0000_0000, 15'h0, 13'd0};
    vecs[2] = '{0, 8'h00, 1, 0, 0, 32'h0000_0000, 15'h0, 13'd0};
    vecs[3] = '{1, 8'h2A, 0, 0, 0, 32'h0000_0000, 15'h0, 13'd0};
    vecs[4] = '{0, 8'h00, 0, 0, 1, 32'h0003_002A, 15'h0, 13'd0};
    vecs[5] = '{0, 8'h00, 0, 0, 0, 32'h0003_002A, 15'h0, 13'd1};
    vecs[6] = '{0, 8'h00, 0, 0, 0, 32'h0003_002A, 15'h0, 13'd1};
    for (int i = 0; i < 7; i++) begin
      applyStimulus(vecs[i].sv, vecs[i].sd, vecs[i].tk, vecs[i].wr);
      checkOutput("tbl_write", avm_write, vecs[i].exp_write);
      checkOutput("tbl_data", avm_writedata, vecs[i].exp_data);
      checkOutput("tbl_addr", avm_address, vecs[i].exp_addr);
      checkOutput("tbl_ptr", wr_ptr, vecs[i].exp_ptr);
    end

    // Five stalled cycles: request frozen, single advance afterwards
    applyStimulus(1, 8'h11, 0, 1);
    applyStimulus(0, 8'h00, 0, 1);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(0, 8'h00, 0, 1);
      checkOutput("stall_write", avm_write, 1);
      checkOutput("stall_addr", avm_address, BASE_ADDR + 4);
      checkOutput("stall_data", avm_writedata, 32'h0003_0011);
    end
    applyStimulus(0, 8'h00, 0, 0);
    applyStimulus(0, 8'h00, 0, 0);
    checkOutput("stall_ptr", wr_ptr, 2);

    // Six samples into a stalled 4-deep FIFO
    applyStimulus(0, 8'h00, 0, 0, 1, 1);
    applyStimulus(0, 8'h00, 0, 0);
    dut_log.delete();
    for (int i = 0; i < 6; i++) applyStimulus(1, 8'(8'h40 + i), 0, 1);
    for (int i = 0; i < 14; i++) applyStimulus(0, 8'h00, 0, 1);
    checkOutput("ovf_set", overflow, 1);
    for (int i = 0; i < 12; i++) applyStimulus(0, 8'h00, 0, 0);
    checkOutput("ovf_count", dut_log.size(), 4);
    for (int i = 0; i < 4 && i < dut_log.size(); i++)
      checkOutput("ovf_order", dut_log[i], 32'h0000_0040 + i);
    checkOutput("ovf_sticky", overflow, 1);
    applyStimulus(0, 8'h00, 0, 0, 1, 1);
    checkOutput("ovf_cleared", overflow, 0);

    // Fill to the last word, then wrap
    for (int i = 0; i < NUM_WORDS - 1; i++) begin
      applyStimulus(1, i[7:0], 0, 0);
      applyStimulus(0, 8'h00, 0, 0);
      applyStimulus(0, 8'h00, 0, 0);
    end
    checkOutput("wrap_pre_ptr", wr_ptr, NUM_WORDS - 1);
    applyStimulus(1, 8'h5A, 0, 0);
    applyStimulus(0, 8'h00, 0, 0);
    checkOutput("wrap_addr", avm_address, BASE_ADDR + 19996);
    applyStimulus(0, 8'h00, 0, 0);
    checkOutput("wrap_ptr", wr_ptr, 0);
    checkOutput("wrap_count", wrap_count, 1);

    // Clear during a stalled write
    applyStimulus(0, 8'h00, 1, 0);
    applyStimulus(1, 8'h33, 1, 0);
    applyStimulus(0, 8'h00, 0, 1);
    applyStimulus(0, 8'h00, 0, 1, 1, 1);
    applyStimulus(0, 8'h00, 0, 1);
    checkOutput("clr_hold", avm_write, 1);
    applyStimulus(0, 8'h00, 0, 0);
    checkOutput("clr_done_ptr", wr_ptr, 1);
    applyStimulus(0, 8'h00, 0, 0);
    checkOutput("clr_ptr", wr_ptr, 0);
    checkOutput("clr_wraps", wrap_count, 0);
    checkOutput("clr_busy", busy, 0);
    applyStimulus(1, 8'h44, 0, 0);
    applyStimulus(0, 8'h00, 0, 0);
    checkOutput("clr_ts", avm_writedata, 32'h0000_0044);
    applyStimulus(0, 8'h00, 0, 0);

    // Tick and sample together use the pre-increment timestamp
    for (int i = 0; i < 7; i++) applyStimulus(0, 8'h00, 1, 0);
    applyStimulus(1, 8'h66, 1, 0);
    applyStimulus(0, 8'h00, 0, 0);
    checkOutput("tick_same", avm_writedata, 32'h0007_0066);
    applyStimulus(0, 8'h00, 0, 0);
    applyStimulus(1, 8'h67, 0, 0);
    applyStimulus(0, 8'h00, 0, 0);
    checkOutput("tick_next", avm_writedata, 32'h0008_0067);
    applyStimulus(0, 8'h00, 0, 0);

    // Disable mid-stream: queued records still drain
    dut_log.delete();
    for (int i = 0; i < 3; i++) applyStimulus(1, 8'(8'h70 + i), 0, 1);
    for (int i = 0; i < 2; i++) applyStimulus(1, 8'h7F, 0, 1, 0);
    for (int i = 0; i < 8; i++) applyStimulus(0, 8'h00, 0, 0, 0);
    checkOutput("disable_drain", dut_log.size(), 3);

    // Reset in the middle of a stalled write
    applyStimulus(1, 8'h55, 0, 1);
    applyStimulus(0, 8'h00, 0, 1);
    applyStimulus(0, 8'h00, 0, 1, 1, 0, 1);
    checkOutput("rst_write", avm_write, 0);
    checkOutput("rst_ptr", wr_ptr, 0);

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      applyStimulus($urandom_range(2) == 0, 8'($urandom), $urandom_range(3) == 0,
                    $urandom_range(1) == 1, $urandom_range(7) != 0, $urandom_range(99) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
